// File: rtl/fp_add_sequencer.sv
// Front end for floating_point_adder: packs IEEE-754 operand pairs into the adder's field layout,
// strobes load (issuing bubbles to drain), and returns results in order through a credit-guarded FIFO.
module fp_add_sequencer #(
  parameter int PIPE_DEPTH = 4,
  parameter int RES_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_op,
  output logic [15:0] exponenti,
  output logic [47:0] mantise,
  output logic        op,
  output logic        load,
  input  logic [7:0]  rez_exp,
  input  logic [23:0] rez_mant,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data
);

  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam int AW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

  typedef struct packed {
    logic [15:0] exponenti;
    logic [47:0] mantise;
    logic        op;
  } issue_t;

  issue_t              iss_q, iss_d;
  logic                load_q, load_d;
  logic [PIPE_DEPTH:0] vld_pipe_q, vld_pipe_d;
  logic                cap_pend_q, cap_pend_d;
  logic [CW-1:0]       outst_q, outst_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [31:0]         mem_q [RES_DEPTH];
  logic [31:0]         mem_d [RES_DEPTH];

  logic        accept, pop, push, in_flight;
  logic [31:0] cap_word;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (outst_q < CW'(RES_DEPTH));
  assign res_valid = (cnt_q != '0);
  assign res_data  = res_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign exponenti = iss_q.exponenti;
  assign mantise   = iss_q.mantise;
  assign op        = iss_q.op;
  assign load      = load_q;

  assign accept    = in_valid & in_ready;
  assign pop       = res_valid & res_ready;
  assign push      = cap_pend_q;
  // Bit PIPE_DEPTH is excluded: its result surfaces on the current load, no further bubble needed.
  assign in_flight = |vld_pipe_q[PIPE_DEPTH-1:0];
  assign cap_word  = {rez_mant[23], rez_exp, rez_mant[22:0]};

  // Issue register and tag pipe; the tag shifts on the same edge its load is presented.
  always_comb begin
    iss_d      = iss_q;
    load_d     = 1'b0;
    vld_pipe_d = vld_pipe_q;
    if (accept) begin
      load_d          = 1'b1;
      iss_d.exponenti = {in_a[30:23], in_b[30:23]};
      iss_d.mantise   = {in_a[31], in_a[22:0], in_b[31], in_b[22:0]};
      iss_d.op        = in_op;
    end else if (in_flight) begin
      load_d = 1'b1;
      iss_d  = '0;
    end
    if (load_d) vld_pipe_d = {vld_pipe_q[PIPE_DEPTH-1:0], accept};
    cap_pend_d = load_q & vld_pipe_q[PIPE_DEPTH];
  end

  always_comb begin
    outst_d = outst_q;
    case ({accept, pop})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = cap_word;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      iss_q      <= '0;
      load_q     <= 1'b0;
      vld_pipe_q <= '0;
      cap_pend_q <= 1'b0;
      outst_q    <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_q      <= '{default: '0};
    end else begin
      iss_q      <= iss_d;
      load_q     <= load_d;
      vld_pipe_q <= vld_pipe_d;
      cap_pend_q <= cap_pend_d;
      outst_q    <= outst_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: doc/fp_add_sequencer.md
# fp_add_sequencer

Host-side front end for `floating_point_adder`. Accepts IEEE-754 single-precision operand pairs over a valid/ready handshake, packs them into the adder's `exponenti`/`mantise` format, and pulses `load` to advance the adder pipeline. It inserts bubble loads to drain the pipeline, recovers each result from `rez_exp`/`rez_mant`, and returns it as a 32-bit word through a credit-protected result FIFO.

## Interface
- `PIPE_DEPTH`, 4: number of further `load` pulses the adder needs before the result of a load appears on `rez_*`.
- `RES_DEPTH`, 4: result FIFO entries; also the maximum number of outstanding operations (power of two, ≥ 1).
- `clk` in 1: clock; all logic is on the rising edge.
- `clear` in 1: asynchronous active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: the block accepts the operand pair this cycle.
- `in_a` in 32: operand A (IEEE-754).
- `in_b` in 32: operand B (IEEE-754).
- `in_op` in 1: operation; 0 = add, 1 = subtract. Forwarded to the adder unchanged.
- `exponenti` out 16: adder exponents, `{a[30:23], b[30:23]}`.
- `mantise` out 48: adder sign and mantissa fields, `{a[31], a[22:0], b[31], b[22:0]}`.
- `op` out 1: adder operation select.
- `load` out 1: one-cycle adder advance strobe.
- `rez_exp` in 8: adder result exponent.
- `rez_mant` in 24: adder result, `{sign, mantissa[22:0]}`.
- `res_valid` out 1: result FIFO not empty.
- `res_ready` in 1: consumer pops the result.
- `res_data` out 32: `{rez_mant[23], rez_exp, rez_mant[22:0]}` of the FIFO head.

## Operation
- **Reset values:**
  - `load`, `op`, `res_valid` = 0; `exponenti`, `mantise`, `res_data` = 0.
  - `in_ready` = 1.
  - Tag shift register, outstanding counter and FIFO pointers are cleared.
- **Reset mid-operation:** all in-flight and buffered results are discarded, and `load` drops immediately.
- **Outstanding counter** (0..`RES_DEPTH`):
  - +1 on input accept (`in_valid & in_ready`).
  - −1 on result pop (`res_valid & res_ready`).
  - Both in the same cycle leaves it unchanged.
- `in_ready` = (outstanding < `RES_DEPTH`). This guarantees the FIFO cannot overflow, so no result is ever dropped.
- **Issue register:** `exponenti`, `mantise`, `op`, `load` are registered and updated every edge.
  - **Accept:** `load` ← 1, fields packed from `in_a`/`in_b`, `op` ← `in_op`; a valid tag (1) is shifted in.
  - **Else, if any valid tag is in flight:** bubble load. `load` ← 1, `exponenti`/`mantise`/`op` ← 0, and a 0 tag is shifted in.
  - **Else:** `load` ← 0 and the fields hold their values.
- **Tag shift register:** `PIPE_DEPTH`+1 bits, shifted only on cycles where `load` = 1. The bit leaving the last position marks the load whose result is now on `rez_*`.
- **Capture:**
  - When `load` = 1 and the exiting tag = 1, set `cap_pend`.
  - In the following cycle, push `{rez_mant[23], rez_exp, rez_mant[22:0]}` into the FIFO and clear `cap_pend`.
- **Result FIFO:** synchronous, `RES_DEPTH` entries. Push and pop in the same cycle are both performed. `res_data` shows the head entry; it is 0 when the FIFO is empty.
- **Ordering:** results leave in acceptance order.
- **Idle:** bubbles stop once no valid tag remains; with no input, `load` stays 0.

## Timing
- Input accepted at edge E0 → `load` = 1 during cycle 1.
- For an isolated operation:
  - Bubble loads in cycles 2..`PIPE_DEPTH`+1.
  - `rez_*` is valid in cycle `PIPE_DEPTH`+2 and is captured at the end of that cycle.
  - `res_valid` = 1 in cycle `PIPE_DEPTH`+3, i.e. 7 cycles for the default depth.
- Back-to-back accepts give one `load` per cycle and one result per cycle once the pipeline is full.
- Holding `res_ready` = 0 stalls input after `RES_DEPTH` accepts. Already-issued operations still drain into the FIFO.
- `res_data` and `res_valid` are stable while `res_valid` = 1 and `res_ready` = 0.

## Test plan
- **Reset:** assert `clear` = 0 mid-stream. Outputs go to their reset values at once, `in_ready` = 1, and no stale result appears after release.
- **Single operation:** A = 0x40900000, B = 0x40500000, `in_op` = 0.
  - Cycle 1: `exponenti` = 0x8180, `mantise` = 0x100000500000.
  - `res_data` = 0x40F80000 at cycle 7, followed by exactly 4 bubble loads and then `load` = 0.
- **Back-to-back operations:** accept in consecutive cycles 0x40900000 − 0x40900000 (op 1), 0x3FA00000 − 0x40700000 (op 1), 0xC0B80000 + 0x40600000 (op 0).
  - Results in order: 0x00000000, 0xC0200000, 0xC0100000, on consecutive cycles.
- **Backpressure:** hold `res_ready` = 0 and offer 6 operations.
  - Exactly 4 are accepted and `in_ready` = 0 afterwards.
  - Releasing `res_ready` pops the 4 results in order. The remaining 2 are then accepted and complete correctly.
- **Simultaneous accept and pop at full:** outstanding = 4, pop and new offer in the same cycle.
  - The pop frees a credit (`in_ready` returns to 1) and the offered operation is accepted on a following cycle.
  - No FIFO overflow or loss; the counter never exceeds 4.
- **Interleaved idle gaps:** insert random `in_valid` gaps during a stream.
  - Bubble loads carry zero fields.
  - Every result matches the bench's reference adder model, which has latency `PIPE_DEPTH`.
